// File: rtl/iomem_bridge_pkg.sv
// iomem_wb_bridge shared definitions: FSM states, GPIO register
// offsets, fixed response words and a byte-strobe helper.
package iomem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WB_ACCESS = 2'd1,
        ST_RESPOND   = 2'd2
    } state_e;

    localparam logic [1:0] GPIO_OFF_DATA = 2'd0;
    localparam logic [1:0] GPIO_OFF_SET  = 2'd1;
    localparam logic [1:0] GPIO_OFF_CLR  = 2'd2;
    localparam logic [1:0] GPIO_OFF_TOG  = 2'd3;

    localparam logic [31:0] RDATA_UNMAPPED = 32'hFFFF_FFFF;
    localparam logic [31:0] RDATA_TIMEOUT  = 32'hDEAD_BEEF;

    // Expand four byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}},
                {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/iomem_gpio_regs.sv
// GPIO output register bank with DATA, SET, CLR and TOG aliases.
// Byte strobes qualify every write; bits above GPIO_WIDTH are dropped.
module iomem_gpio_regs
    import iomem_bridge_pkg::*;
#(
    parameter int GPIO_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [1:0]            off_i,
    input  logic [3:0]            wstrb_i,
    input  logic [31:0]           wdata_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [31:0]           rdata_o
);

    logic [GPIO_WIDTH-1:0] gpio_q;
    logic [GPIO_WIDTH-1:0] gpio_d;
    logic [31:0]           cur;
    logic [31:0]           mask;
    logic [31:0]           bits;
    logic [31:0]           nxt;

    // Compute the register value after the addressed alias operation.
    always_comb begin
        cur = '0;
        cur[GPIO_WIDTH-1:0] = gpio_q;
        mask = strb_mask(wstrb_i);
        bits = wdata_i & mask;
        nxt  = cur;
        unique case (off_i)
            GPIO_OFF_DATA: nxt = (cur & ~mask) | bits;
            GPIO_OFF_SET:  nxt = cur | bits;
            GPIO_OFF_CLR:  nxt = cur & ~bits;
            GPIO_OFF_TOG:  nxt = cur ^ bits;
            default:       nxt = cur;
        endcase
        gpio_d = we_i ? nxt[GPIO_WIDTH-1:0] : gpio_q;
    end

    // GPIO state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gpio_q <= '0;
        end else begin
            gpio_q <= gpio_d;
        end
    end

    assign gpio_o  = gpio_q;
    assign rdata_o = cur;

endmodule

// File: rtl/iomem_wb_bridge.sv
// PicoSoC iomem hub: decodes the address top byte to a GPIO bank or
// one of NUM_SLAVES Wishbone channels, with timeout and error reporting.
module iomem_wb_bridge
    import iomem_bridge_pkg::*;
#(
    parameter int                        NUM_SLAVES     = 2,
    parameter logic [NUM_SLAVES*8-1:0]   SLAVE_BASE     = {8'h31, 8'h30},
    parameter logic [7:0]                GPIO_BASE      = 8'h03,
    parameter int                        GPIO_WIDTH     = 32,
    parameter int                        TIMEOUT_CYCLES = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     iomem_valid,
    input  logic [3:0]               iomem_wstrb,
    input  logic [31:0]              iomem_addr,
    input  logic [31:0]              iomem_wdata,
    output logic                     iomem_ready,
    output logic [31:0]              iomem_rdata,
    output logic [NUM_SLAVES-1:0]    wbm_cyc_o,
    output logic [NUM_SLAVES-1:0]    wbm_stb_o,
    output logic                     wbm_we_o,
    output logic [3:0]               wbm_sel_o,
    output logic [31:0]              wbm_addr_o,
    output logic [31:0]              wbm_dat_o,
    input  logic [NUM_SLAVES*32-1:0] wbm_dat_i,
    input  logic [NUM_SLAVES-1:0]    wbm_ack_i,
    output logic [GPIO_WIDTH-1:0]    gpio_o,
    output logic                     bus_err_o,
    output logic [31:0]              err_addr_o
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [NUM_SLAVES-1:0] cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [3:0]            sel_q, sel_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdat_q, wdat_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [31:0]           eaddr_q, eaddr_d;

    logic                  hit_gpio;
    logic [NUM_SLAVES-1:0] hit_ch;
    logic                  ack_sel;
    logic [31:0]           ch_rdata;
    logic                  gpio_we;
    logic [31:0]           gpio_rdata;

    iomem_gpio_regs #(
        .GPIO_WIDTH(GPIO_WIDTH)
    ) u_gpio (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .we_i   (gpio_we),
        .off_i  (iomem_addr[3:2]),
        .wstrb_i(iomem_wstrb),
        .wdata_i(iomem_wdata),
        .gpio_o (gpio_o),
        .rdata_o(gpio_rdata)
    );

    // Address decode; scanning downward leaves the lowest matching channel.
    always_comb begin
        hit_gpio = (iomem_addr[31:24] == GPIO_BASE);
        hit_ch   = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (iomem_addr[31:24] == SLAVE_BASE[i*8 +: 8]) begin
                hit_ch    = '0;
                hit_ch[i] = 1'b1;
            end
        end
    end

    // Ack and read data of the channel that currently owns the cycle.
    always_comb begin
        ack_sel  = |(wbm_ack_i & cyc_q);
        ch_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (cyc_q[i]) begin
                ch_rdata = ch_rdata | wbm_dat_i[i*32 +: 32];
            end
        end
    end

    // Transaction FSM next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        eaddr_d = eaddr_q;
        gpio_we = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (iomem_valid) begin
                    addr_d = iomem_addr;
                    wdat_d = iomem_wdata;
                    sel_d  = iomem_wstrb;
                    if (hit_gpio) begin
                        gpio_we = |iomem_wstrb;
                        rdata_d = (|iomem_wstrb) ? 32'h0 : gpio_rdata;
                        ready_d = 1'b1;
                        state_d = ST_RESPOND;
                    end else if (|hit_ch) begin
                        cyc_d   = hit_ch;
                        we_d    = |iomem_wstrb;
                        cnt_d   = '0;
                        state_d = ST_WB_ACCESS;
                    end else begin
                        rdata_d = RDATA_UNMAPPED;
                        err_d   = 1'b1;
                        eaddr_d = iomem_addr;
                        ready_d = 1'b1;
                        state_d = ST_RESPOND;
                    end
                end
            end
            ST_WB_ACCESS: begin
                if (ack_sel) begin
                    cyc_d   = '0;
                    rdata_d = we_q ? 32'h0 : ch_rdata;
                    ready_d = 1'b1;
                    state_d = ST_RESPOND;
                end else if (cnt_q == TO_LAST) begin
                    cyc_d   = '0;
                    rdata_d = RDATA_TIMEOUT;
                    err_d   = 1'b1;
                    eaddr_d = addr_q;
                    ready_d = 1'b1;
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            eaddr_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            eaddr_q <= eaddr_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_addr_o  = addr_q;
    assign wbm_dat_o   = wdat_q;
    assign bus_err_o   = err_q;
    assign err_addr_o  = eaddr_q;

endmodule
